// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl: multicycle CPU phase FSM (HALT/IF/ID/EX/MEM/WB); in: clk rst_n start mem_ready halt_instr is_*; out: mem_rd_req ir/pc/mdr/reg_we regsrc_op phase halted mem_err instret
module cpu_phase_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_ready,
  input  logic        halt_instr,
  input  logic        is_load,
  input  logic        is_li,
  input  logic        is_link,
  input  logic        is_alu,
  output logic        mem_rd_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        mdr_we,
  output logic        reg_we,
  output logic [1:0]  regsrc_op,
  output logic [2:0]  phase,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] instret
);
  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;
  state_t state;
  logic [7:0] wcnt;
  logic busy, tout, wb;
  assign busy = state == S_IF || state == S_MEM;
  assign tout = busy && !mem_ready && wcnt == 8'(MEM_TIMEOUT - 1);
  assign wb = state == S_WB;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_HALT;
      wcnt <= 8'd0;
      mem_err <= 1'b0;
      instret <= 16'd0;
    end else begin
      wcnt <= busy && !mem_ready && !tout ? wcnt + 8'd1 : 8'd0;
      if (tout) mem_err <= 1'b1;
      else if (state == S_HALT && start) mem_err <= 1'b0;
      if (wb) instret <= instret + 16'd1;
      case (state)
        S_HALT:  state <= start ? S_IF : S_HALT;
        S_IF:    state <= mem_ready ? S_ID : tout ? S_HALT : S_IF;
        S_ID:    state <= halt_instr ? S_HALT : S_EX;
        S_EX:    state <= is_load ? S_MEM : S_WB;
        S_MEM:   state <= mem_ready ? S_WB : tout ? S_HALT : S_MEM;
        S_WB:    state <= S_IF;
        default: state <= S_HALT;
      endcase
    end
  always_comb begin
    mem_rd_req = busy;
    ir_we = state == S_IF && mem_ready;
    pc_we = state == S_IF && mem_ready;
    mdr_we = state == S_MEM && mem_ready;
    reg_we = wb && (is_load || is_li || is_link || is_alu);
    regsrc_op = !wb ? 2'b00 : is_load ? 2'b01 : is_li ? 2'b10 : is_link ? 2'b11 : 2'b00;
    phase = state;
    halted = state == S_HALT;
  end
endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// tb_cpu_phase_ctrl: instruction-level scoreboard bench for cpu_phase_ctrl
module tb_cpu_phase_ctrl;
  localparam int TO = 15;
  logic clk = 1'b0, rst_n, start, mem_ready, halt_instr, is_load, is_li, is_link, is_alu;
  logic mem_rd_req, ir_we, pc_we, mdr_we, reg_we, halted, mem_err;
  logic [1:0] regsrc_op;
  logic [2:0] phase;
  logic [15:0] instret;
  typedef struct packed {
    logic [2:0] ph;
    logic rd, ir, pc, mdr, rwe;
    logic [1:0] src;
    logic hlt, err;
    logic [15:0] ret;
  } obs_t;
  obs_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  logic m_err;
  logic [15:0] m_ret;
  bit s;
  cpu_phase_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready), .halt_instr(halt_instr),
    .is_load(is_load), .is_li(is_li), .is_link(is_link), .is_alu(is_alu),
    .mem_rd_req(mem_rd_req), .ir_we(ir_we), .pc_we(pc_we), .mdr_we(mdr_we), .reg_we(reg_we),
    .regsrc_op(regsrc_op), .phase(phase), .halted(halted), .mem_err(mem_err), .instret(instret)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    obs_t got, e;
    cyc++;
    if (q.size() != 0) begin
      e = q.pop_front();
      got = '{phase, mem_rd_req, ir_we, pc_we, mdr_we, reg_we, regsrc_op, halted, mem_err, instret};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle %0d outputs{ph,rd,ir,pc,mdr,rwe,src,hlt,err,ret}: got %h expected %h", cyc, got, e);
      end
    end
  end
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic step(input logic st, rdy, hi, ld, li, lk, al, input logic [2:0] ph,
                      input logic ir, mdr, rwe, input logic [1:0] src);
    obs_t e;
    start = st; mem_ready = rdy; halt_instr = hi;
    is_load = ld; is_li = li; is_link = lk; is_alu = al;
    e = '{ph: ph, rd: (ph == 3'd1 || ph == 3'd4), ir: ir, pc: ir, mdr: mdr, rwe: rwe, src: src,
          hlt: (ph == 3'd0), err: m_err, ret: m_ret};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic restart(input int n);
    repeat (n) step(1'b0, rb(), rb(), rb(), rb(), rb(), rb(), 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b1, rb(), rb(), rb(), rb(), rb(), rb(), 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    m_err = 1'b0;
  endtask
  // Expands one instruction into its cycle trace: wif/wmem are not-ready cycles before data
  // arrives; a wait of TO or more ends the access in HALT with the error flag.
  task automatic instr(input int wif, wmem, input bit hlt, ld, input logic li, lk, al, output bit stopped);
    stopped = 1'b0;
    for (int i = 0; i < wif && i < TO; i++)
      step(rb(), 1'b0, rb(), rb(), rb(), rb(), rb(), 3'd1, 1'b0, 1'b0, 1'b0, 2'b00);
    if (wif >= TO) begin m_err = 1'b1; stopped = 1'b1; return; end
    step(rb(), 1'b1, rb(), rb(), rb(), rb(), rb(), 3'd1, 1'b1, 1'b0, 1'b0, 2'b00);
    step(rb(), rb(), hlt, rb(), rb(), rb(), rb(), 3'd2, 1'b0, 1'b0, 1'b0, 2'b00);
    if (hlt) begin stopped = 1'b1; return; end
    step(rb(), rb(), rb(), ld, rb(), rb(), rb(), 3'd3, 1'b0, 1'b0, 1'b0, 2'b00);
    if (ld) begin
      for (int i = 0; i < wmem && i < TO; i++)
        step(rb(), 1'b0, rb(), rb(), rb(), rb(), rb(), 3'd4, 1'b0, 1'b0, 1'b0, 2'b00);
      if (wmem >= TO) begin m_err = 1'b1; stopped = 1'b1; return; end
      step(rb(), 1'b1, rb(), rb(), rb(), rb(), rb(), 3'd4, 1'b0, 1'b1, 1'b0, 2'b00);
    end
    step(rb(), rb(), rb(), ld, li, lk, al, 3'd5, 1'b0, 1'b0, ld | li | lk | al,
         ld ? 2'b01 : li ? 2'b10 : lk ? 2'b11 : 2'b00);
    m_ret = m_ret + 16'd1;
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; halt_instr = 1'b0;
    is_load = 1'b0; is_li = 1'b0; is_link = 1'b0; is_alu = 1'b0;
    m_err = 1'b0; m_ret = 16'd0;
    @(posedge clk);
    #1;
    repeat (2) step(rb(), rb(), rb(), rb(), rb(), rb(), rb(), 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;
    restart(2);
    repeat (3) instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
    instr(0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
    instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, s);
    instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
    instr(TO - 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
    instr(0, TO - 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, s);
    instr(TO, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
    restart(2);
    instr(0, TO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
    restart(1);
    instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, s);
    restart(1);
    for (int n = 0; n < 300; n++) begin
      int wif, wmem;
      wif = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 3));
      wmem = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 3));
      instr(wif, wmem, $urandom_range(0, 15) == 0, rb(), rb(), rb(), rb(), s);
      if (s) restart($urandom_range(0, 3));
    end
    instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s);
    force dut.instret = 16'hfffe;
    m_ret = 16'hfffe;
    step(1'b0, rb(), rb(), rb(), rb(), rb(), rb(), 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    release dut.instret;
    restart(1);
    repeat (3) instr(0, $urandom_range(0, 2), 1'b0, rb(), rb(), rb(), rb(), s);
    step(rb(), 1'b1, rb(), rb(), rb(), rb(), rb(), 3'd1, 1'b1, 1'b0, 1'b0, 2'b00);
    step(rb(), rb(), 1'b0, rb(), rb(), rb(), rb(), 3'd2, 1'b0, 1'b0, 1'b0, 2'b00);
    step(rb(), rb(), rb(), 1'b1, rb(), rb(), rb(), 3'd3, 1'b0, 1'b0, 1'b0, 2'b00);
    step(rb(), 1'b0, rb(), rb(), rb(), rb(), rb(), 3'd4, 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b0;
    m_err = 1'b0; m_ret = 16'd0;
    step(rb(), 1'b1, rb(), rb(), rb(), rb(), rb(), 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;
    repeat (3) step(1'b0, rb(), rb(), rb(), rb(), rb(), rb(), 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    restart(0);
    instr(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_phase_ctrl.md
CPU_PHASE_CTRL -- requirements
Module: cpu_phase_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state updates SHALL occur on the rising clock edge.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  level; leaves HALT and begins fetch.
REQ-005 mem_ready  in  1  memory read data valid this cycle.
REQ-006 halt_instr  in  1  decoded HLT, sampled in ID.
REQ-007 is_load, is_li, is_link, is_alu  in  1 each  decoded writeback class, sampled in WB.
REQ-008 mem_rd_req  out  1  memory read request.
REQ-009 ir_we, pc_we, mdr_we, reg_we  out  1 each  write strobes for IR, PC, MDR, register file.
REQ-010 regsrc_op  out  2  register-source mux select: 00 DR, 01 MDR, 10 immediate, 11 PC+1.
REQ-011 phase  out  3  current state encoding.
REQ-012 halted  out  1  high in HALT.
REQ-013 mem_err  out  1  sticky memory-timeout flag.
REQ-014 instret  out  16  retired-instruction count.
REQ-015 Parameter MEM_TIMEOUT, default 15, maximum wait cycles per memory access (range 1..255).

Function
REQ-016 States SHALL be HALT=0, IF=1, ID=2, EX=3, MEM=4, WB=5; codes 6-7 SHALL go to HALT on the next edge.
REQ-017 HALT: stay while start=0; start=1 -> IF on next edge and clear mem_err on that edge.
REQ-018 start SHALL be ignored in every state except HALT.
REQ-019 IF: mem_rd_req=1; when mem_ready=1, ir_we=1 and pc_we=1 in that same cycle, then -> ID.
REQ-020 ID: halt_instr=1 -> HALT; otherwise -> EX.
REQ-021 EX: -> MEM if is_load=1, else -> WB.
REQ-022 MEM: mem_rd_req=1; when mem_ready=1, mdr_we=1 in that same cycle, then -> WB.
REQ-023 WB: reg_we=1 if any is_* is high; regsrc_op by priority is_load 01 > is_li 10 > is_link 11 > is_alu 00; then -> IF.
REQ-024 WB with no is_* high: reg_we=0, regsrc_op=00; the instruction SHALL still retire.
REQ-025 Outside WB, reg_we SHALL be 0 and regsrc_op SHALL be 00.
REQ-026 mem_rd_req, phase and halted SHALL be Moore outputs (state only).
REQ-027 ir_we, pc_we and mdr_we SHALL be Mealy outputs gated by mem_ready and state; they SHALL be 0 in every other state.
REQ-028 Wait counter (8-bit): SHALL clear on entry to IF/MEM and increment each IF/MEM cycle with mem_ready=0.
REQ-029 When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next edge SHALL go to HALT and set mem_err=1; no strobe SHALL fire.
REQ-030 mem_ready=1 in the same cycle the timeout is reached SHALL win: normal completion, no error.
REQ-031 mem_ready SHALL be ignored outside IF/MEM.
REQ-032 instret SHALL increment by 1 on each WB exit and wrap 0xFFFF -> 0x0000; HLT SHALL not count.
REQ-033 Minimum latency: non-load 4 cycles (IF, ID, EX, WB); load 5 cycles; each wait cycle adds 1.

Reset
REQ-034 rst_n=0 SHALL immediately force HALT and set halted=1, all strobes 0, mem_rd_req=0, regsrc_op=00, mem_err=0, instret=0, wait counter=0, independent of clk.
REQ-035 Reset asserted mid-access SHALL abort the access with no strobe; after release the block SHALL stay in HALT until start.

Verification
REQ-036 Reset, then start=1, mem_ready=1 constant, is_alu=1 -> phase 1,2,3,5,1...; reg_we=1 with regsrc_op=00 every 4th cycle; instret=3 after 12 cycles.
REQ-037 Load with mem_ready=0 for 2 cycles in MEM -> mdr_we pulses once on the 3rd MEM cycle; WB shows regsrc_op=01 and reg_we=1; total 7 cycles.
REQ-038 is_li=1 and is_link=1 together in WB -> regsrc_op=10; is_link alone -> 11; all is_* low -> reg_we=0, instret still increments.
REQ-039 mem_ready held 0 in IF with MEM_TIMEOUT=15 -> HALT after the 15th wait cycle; mem_err=1, halted=1; then start=1 -> mem_err=0, phase=1.
REQ-040 halt_instr=1 in ID -> HALT with instret unchanged; start toggled outside HALT has no effect.
REQ-041 instret preset near 0xFFFF by running 65535 instructions -> next WB gives 0x0000; rst_n pulsed low in MEM -> HALT immediately with all outputs at reset values.
